// File: rtl/sum_fact_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sum_fact_arbiter
// Purpose  : Round-robin scheduler that shares one sum-of-factorials engine
//            among NUM_REQ requesters.
//
//            Each job runs through the same sequence:
//              - pick a pending requester and capture its N;
//              - clear the engine and launch it;
//              - wait for the result;
//              - hand the result back with the requester ID.
//
//            Only one job is in flight at a time.
//
// Ports    : clk, reset          - clock / synchronous active-high reset
//            req_valid/req_N     - per-requester job request (N slice k at
//                                  [3k+2:3k])
//            req_ready           - one-hot single-cycle grant pulse
//            rsp_valid/rsp_id/rsp_data/rsp_err/rsp_ack
//                                - response channel; fields held until ack
//            eng_*               - engine pins (reset, N_in, input_valid,
//                                  sum_fact, output_valid, output_ack)
//
// Options  : SUM_FACT_ARB_TIMEOUT_EN
//              - When defined: a WAIT that lasts TIMEOUT_CYC cycles without
//                eng_output_valid yields a response with rsp_err=1 and
//                rsp_data=0.
//              - When undefined: WAIT waits indefinitely and rsp_err is
//                tied 0.
//
// Revision : 1.0 - initial release
// ============================================================================
module sum_fact_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ID_W        = 2,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [3*NUM_REQ-1:0] req_N,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 rsp_valid,
   output logic [ID_W-1:0]      rsp_id,
   output logic [12:0]          rsp_data,
   output logic                 rsp_err,
   input  logic                 rsp_ack,
   output logic                 eng_reset,
   output logic [2:0]           eng_N_in,
   output logic                 eng_input_valid,
   input  logic [12:0]          eng_sum_fact,
   input  logic                 eng_output_valid,
   output logic                 eng_output_ack
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_LAUNCH = 3'd2,
      S_WAIT   = 3'd3,
      S_RESP   = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ID_W-1:0]   r_rr_ptr;
   logic [ID_W-1:0]   r_job_id;
   logic [2:0]        r_job_n;
   logic [ID_W-1:0]   r_rsp_id;
   logic [12:0]       r_rsp_data;

   logic              w_found;
   logic [ID_W-1:0]   w_grant_idx;
   logic [NUM_REQ-1:0] w_grant_oh;
   logic [2:0]        w_grant_n;
   logic [2:0]        w_req_n [NUM_REQ];
   logic              w_timeout;

   // (base + off) mod NUM_REQ; off is always below NUM_REQ, so a single
   // conditional subtract is enough.
   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return ID_W'(sum);
   endfunction

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_req_split
      assign w_req_n[k] = req_N[3*k+2 : 3*k];
   end

   // Round-robin search starting at r_rr_ptr.
   // The scan runs from the farthest offset down to offset 0, so the nearest
   // pending requester is the last one written and therefore wins.
   always_comb begin
      w_found     = 1'b0;
      w_grant_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[wrap_add(r_rr_ptr, i)]) begin
            w_found     = 1'b1;
            w_grant_idx = wrap_add(r_rr_ptr, i);
         end
      end
   end

   assign w_grant_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_grant_idx;
   assign w_grant_n  = w_req_n[w_grant_idx];

`ifdef SUM_FACT_ARB_TIMEOUT_EN
   localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   logic [TMO_W-1:0] r_tmo_cnt;
   logic             r_rsp_err;

   // The count is cleared in LAUNCH, so it reads k during the (k+1)-th WAIT
   // cycle. Matching TMO_LAST therefore means TIMEOUT_CYC WAIT cycles have
   // passed.
   assign w_timeout = (r_state == S_WAIT) && !eng_output_valid &&
                      (r_tmo_cnt == TMO_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tmo_cnt <= '0;
         r_rsp_err <= 1'b0;
      end else begin
         if (r_state == S_LAUNCH)
            r_tmo_cnt <= '0;
         else if (r_state == S_WAIT)
            r_tmo_cnt <= r_tmo_cnt + 1'b1;

         if ((r_state == S_WAIT) && eng_output_valid)
            r_rsp_err <= 1'b0;
         else if (w_timeout)
            r_rsp_err <= 1'b1;
      end
   end

   assign rsp_err = r_rsp_err;
`else
   assign w_timeout = 1'b0;
   assign rsp_err   = 1'b0;
`endif

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_found) w_state_nxt = S_CLEAR;
         S_CLEAR:  w_state_nxt = S_LAUNCH;
         S_LAUNCH: w_state_nxt = S_WAIT;
         S_WAIT:   if (eng_output_valid || w_timeout) w_state_nxt = S_RESP;
         S_RESP:   if (rsp_ack) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_rr_ptr   <= '0;
         r_job_id   <= '0;
         r_job_n    <= '0;
         r_rsp_id   <= '0;
         r_rsp_data <= '0;
      end else begin
         r_state <= w_state_nxt;

         if ((r_state == S_IDLE) && w_found) begin
            r_job_n  <= w_grant_n;
            r_job_id <= w_grant_idx;
            r_rr_ptr <= wrap_add(w_grant_idx, 1);
         end

         if ((r_state == S_WAIT) && eng_output_valid) begin
            r_rsp_data <= eng_sum_fact;
            r_rsp_id   <= r_job_id;
         end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_id   <= r_job_id;
         end
      end
   end

   // Strobes are gated with reset so that nothing leaks out while the
   // registers are still being cleared.
   assign req_ready       = (!reset && (r_state == S_IDLE) && w_found) ? w_grant_oh : '0;
   assign eng_reset       = reset || (r_state == S_CLEAR);
   assign eng_input_valid = !reset && (r_state == S_LAUNCH);
   assign eng_output_ack  = !reset && (r_state == S_WAIT) && eng_output_valid;
   assign eng_N_in        = r_job_n;
   assign rsp_valid       = !reset && (r_state == S_RESP);
   assign rsp_id          = r_rsp_id;
   assign rsp_data        = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_sum_fact_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_fact_arbiter
// Purpose  : Self-checking bench for sum_fact_arbiter.
//
//            A job-level reference model tracks, for every cycle:
//              - the round-robin pointer;
//              - the job in flight and its age since grant;
//              - the pending response.
//            Every DUT output is compared against that model.
//
//            The engine is replaced by a stub that returns sum(k!) for k=1..N
//            after a programmable or random delay. When enabled, the stub
//            also emits stray output_valid pulses while it is idle.
//
// Revision : 1.0 - initial release
// ============================================================================
module tb_sum_fact_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic                 clk;
   logic                 reset;
   logic [NUM_REQ-1:0]   req_valid;
   logic [3*NUM_REQ-1:0] req_N;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 rsp_valid;
   logic [ID_W-1:0]      rsp_id;
   logic [12:0]          rsp_data;
   logic                 rsp_err;
   logic                 rsp_ack;
   logic                 eng_reset;
   logic [2:0]           eng_N_in;
   logic                 eng_input_valid;
   logic [12:0]          eng_sum_fact;
   logic                 eng_output_valid;
   logic                 eng_output_ack;

   int checks   = 0;
   int failures = 0;

   sum_fact_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .ID_W       (ID_W),
      .TIMEOUT_CYC(64)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_N           (req_N),
      .req_ready       (req_ready),
      .rsp_valid       (rsp_valid),
      .rsp_id          (rsp_id),
      .rsp_data        (rsp_data),
      .rsp_err         (rsp_err),
      .rsp_ack         (rsp_ack),
      .eng_reset       (eng_reset),
      .eng_N_in        (eng_N_in),
      .eng_input_valid (eng_input_valid),
      .eng_sum_fact    (eng_sum_fact),
      .eng_output_valid(eng_output_valid),
      .eng_output_ack  (eng_output_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int fsum(input int n);
      int s;
      int p;
      s = 0;
      p = 1;
      for (int k = 1; k <= n; k++) begin
         p = p * k;
         s = s + p;
      end
      return s;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- engine stub
   int stub_delay = 0;   // 0 selects a random delay of 1..6 cycles
   bit spur_en    = 0;
   bit s_launch, s_ack, s_rst;
   int s_n;
   int st_cnt  = 0;
   bit st_hold = 0;
   int st_n    = 0;
   bit st_spur = 0;
   int d;

   initial begin
      eng_output_valid = 1'b0;
      eng_sum_fact     = '0;
      forever begin
         @(negedge clk);
         s_launch = eng_input_valid;
         s_ack    = eng_output_ack;
         s_rst    = eng_reset;
         s_n      = int'(eng_N_in);
         @(posedge clk);
         #1;
         st_spur = 0;
         if (s_rst) begin
            st_cnt  = 0;
            st_hold = 0;
         end else begin
            if (s_ack) st_hold = 0;
            if (s_launch) begin
               d    = (stub_delay == 0) ? int'($urandom_range(1, 6)) : stub_delay;
               st_n = s_n;
               if (d == 1) st_hold = 1;
               else        st_cnt  = d - 1;
            end else if (st_cnt > 0) begin
               st_cnt--;
               if (st_cnt == 0) st_hold = 1;
            end
         end
         if (spur_en && !st_hold && st_cnt == 0 && $urandom_range(0, 15) == 0)
            st_spur = 1;
         eng_output_valid = st_hold || st_spur;
         eng_sum_fact     = st_hold ? 13'(fsum(st_n))
                          : (st_spur ? 13'($urandom_range(0, 8191)) : 13'd0);
      end
   end

   // ------------------------------------------------------ reference model + compare
   int   m_busy = 0, m_resp = 0, m_age = 0, m_ptr = 0, m_n = 0, m_id = 0, m_data = 0;
   int   gk;
   bit   waiting;
   logic [NUM_REQ-1:0] exp_ready;

   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            chk("rst_req_ready", int'(req_ready), 0);
            chk("rst_rsp_valid", int'(rsp_valid), 0);
            chk("rst_eng_reset", int'(eng_reset), 1);
            chk("rst_eng_input_valid", int'(eng_input_valid), 0);
            chk("rst_eng_output_ack", int'(eng_output_ack), 0);
            m_busy = 0; m_resp = 0; m_age = 0; m_ptr = 0; m_n = 0; m_id = 0;
         end else begin
            gk = -1;
            if (m_busy == 0)
               for (int i = 0; i < NUM_REQ; i++)
                  if (gk < 0 && req_valid[(m_ptr + i) % NUM_REQ]) gk = (m_ptr + i) % NUM_REQ;
            exp_ready = (gk >= 0) ? NUM_REQ'(1 << gk) : '0;
            waiting   = (m_busy != 0) && (m_resp == 0) && (m_age >= 3);

            chk("req_ready", int'(req_ready), int'(exp_ready));
            chk("eng_reset", int'(eng_reset), int'(m_busy != 0 && m_resp == 0 && m_age == 1));
            chk("eng_input_valid", int'(eng_input_valid), int'(m_busy != 0 && m_resp == 0 && m_age == 2));
            chk("eng_N_in", int'(eng_N_in), m_n);
            chk("eng_output_ack", int'(eng_output_ack), int'(waiting && eng_output_valid));
            chk("rsp_valid", int'(rsp_valid), m_resp);
            if (m_resp != 0) begin
               chk("rsp_id", int'(rsp_id), m_id);
               chk("rsp_data", int'(rsp_data), m_data);
               chk("rsp_err", int'(rsp_err), 0);
            end

            if (gk >= 0) begin
               m_busy = 1;
               m_age  = 1;
               m_n    = int'(req_N[3*gk +: 3]);
               m_id   = gk;
               m_ptr  = (gk + 1) % NUM_REQ;
               m_data = fsum(m_n);
            end else if (waiting && eng_output_valid) begin
               m_resp = 1;
            end else if (m_resp != 0 && rsp_ack) begin
               m_resp = 0;
               m_busy = 0;
            end else if (m_busy != 0 && m_resp == 0) begin
               m_age++;
            end
         end
      end
   end

   // ------------------------------------------------------------------- stimulus
   task automatic wait_rsp(input string name);
      int n;
      n = 0;
      while (!rsp_valid && n < 60) begin
         @(posedge clk); #1;
         @(negedge clk);
         n++;
      end
      chk(name, int'(rsp_valid), 1);
   endtask

   int order[$];
   int exp_order[5] = '{0, 1, 2, 3, 0};
   int budget;
   logic [NUM_REQ-1:0] g;

   initial begin
      reset = 1'b1; req_valid = '0; req_N = '0; rsp_ack = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_eng_reset", int'(eng_reset), 1);
      chk("reset_rsp_valid", int'(rsp_valid), 0);

      // Single request on req 1, N=3, engine answers 3 cycles after launch
      @(posedge clk); #1;
      reset = 1'b0; req_valid = 4'b0010; req_N = 12'(3 << 3); stub_delay = 3;
      @(negedge clk); chk("t2_grant", int'(req_ready), 2);
      @(posedge clk); #1; req_valid = '0;
      @(negedge clk); chk("t2_clear", int'(eng_reset), 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t2_launch", int'(eng_input_valid), 1);
      chk("t2_n", int'(eng_N_in), 3);
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk); chk("t2_out_ack", int'(eng_output_ack), 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t2_rsp_valid", int'(rsp_valid), 1);
      chk("t2_rsp_id", int'(rsp_id), 1);
      chk("t2_rsp_data", int'(rsp_data), 9);
      @(posedge clk); #1; rsp_ack = 1'b1;
      @(negedge clk); chk("t2_ack_cycle_valid", int'(rsp_valid), 1);
      @(posedge clk); #1; rsp_ack = 1'b0;
      @(negedge clk); chk("t2_after_ack_valid", int'(rsp_valid), 0);

      // Response held 10 cycles with a pending request on req 0
      @(posedge clk); #1; req_valid = 4'b0001; req_N = 12'd5; stub_delay = 2;
      @(negedge clk); chk("t4_grant", int'(req_ready), 1);
      @(posedge clk); #1; req_N = 12'd2;
      @(negedge clk);
      wait_rsp("t4_rsp_arrives");
      for (int i = 0; i < 10; i++) begin
         chk("t4_hold_valid", int'(rsp_valid), 1);
         chk("t4_hold_data", int'(rsp_data), 153);
         chk("t4_no_grant", int'(req_ready), 0);
         @(posedge clk); #1;
         @(negedge clk);
      end
      @(posedge clk); #1; rsp_ack = 1'b1;
      @(negedge clk); chk("t4_ack_cycle_no_grant", int'(req_ready), 0);
      @(posedge clk); #1; rsp_ack = 1'b0;
      @(negedge clk); chk("t4_grant_after_ack", int'(req_ready), 1);
      @(posedge clk); #1; req_valid = '0;
      @(negedge clk);
      wait_rsp("t4_second_rsp");
      chk("t4_second_data", int'(rsp_data), 3);
      @(posedge clk); #1; rsp_ack = 1'b1;
      @(posedge clk); #1; rsp_ack = 1'b0;

      // Reset for two cycles in the middle of WAIT, then a fresh request on req 2
      req_valid = 4'b0001; req_N = 12'd7; stub_delay = 30;
      @(negedge clk); chk("t1_grant", int'(req_ready), 1);
      @(posedge clk); #1; req_valid = '0;
      repeat (4) begin @(posedge clk); #1; end
      reset = 1'b1; req_valid = 4'b0100; req_N = 12'(4 << 6);
      repeat (2) begin
         @(negedge clk);
         chk("t1_rst_eng_reset", int'(eng_reset), 1);
         chk("t1_rst_rsp_valid", int'(rsp_valid), 0);
         @(posedge clk); #1;
      end
      reset = 1'b0; stub_delay = 0;
      @(negedge clk); chk("t1_regrant", int'(req_ready), 4);
      @(posedge clk); #1; req_valid = '0;
      @(negedge clk);
      wait_rsp("t1_rsp");
      chk("t1_rsp_id", int'(rsp_id), 2);
      chk("t1_rsp_data", int'(rsp_data), 33);
      @(posedge clk); #1; rsp_ack = 1'b1;
      @(posedge clk); #1; rsp_ack = 1'b0;

      // All requesters busy with the ack tied high: order 0,1,2,3,0
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; req_valid = 4'b1111; req_N = 12'h9D3; rsp_ack = 1'b1; stub_delay = 1;
      budget = 0;
      while (order.size() < 5 && budget < 100) begin
         @(negedge clk);
         if (req_ready != '0) begin
            chk("t3_onehot", int'($onehot(req_ready)), 1);
            for (int k = 0; k < NUM_REQ; k++)
               if (req_ready[k]) order.push_back(k);
         end
         @(posedge clk); #1;
         budget++;
      end
      chk("t3_grant_count", order.size(), 5);
      for (int i = 0; i < order.size() && i < 5; i++)
         chk("t3_order", order[i], exp_order[i]);
      req_valid = '0; rsp_ack = 1'b0;

      // Randomised traffic: stray engine pulses, random acks, occasional reset
      spur_en = 1; stub_delay = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         g = req_ready;
         @(posedge clk); #1;
         reset   = ($urandom_range(0, 299) == 0);
         rsp_ack = $urandom_range(0, 1) != 0;
         for (int k = 0; k < NUM_REQ; k++) begin
            if (g[k]) begin
               req_valid[k] = $urandom_range(0, 1) != 0;
               req_N[3*k +: 3] = 3'($urandom_range(0, 7));
            end else if (!req_valid[k]) begin
               if ($urandom_range(0, 3) == 0) begin
                  req_valid[k] = 1'b1;
                  req_N[3*k +: 3] = 3'($urandom_range(0, 7));
               end
            end else if ($urandom_range(0, 31) == 0) begin
               req_valid[k] = 1'b0;
            end
         end
      end
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
